// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the multi-key input controller.
//   SYSTEM_FREQ / GAME_FRAME_RT  : board clock and game frame rate
//   DEFAULT_FRAME_CYCLES         : clk cycles per game frame (rounded)
//   DEFAULT_DEBOUNCE_CYCLES      : 10 ms worth of clk cycles
//   KEY_*                        : bit positions of the board buttons
//   int_state_e                  : interrupt/ack FSM encoding
package input_ctrl_pkg;

  localparam int unsigned SYSTEM_FREQ   = 100_000_000;
  localparam int unsigned GAME_FRAME_RT = 60;

  // Rounded to the nearest whole cycle: 100 MHz / 60 Hz = 1666667.
  localparam int unsigned DEFAULT_FRAME_CYCLES =
    (SYSTEM_FREQ + GAME_FRAME_RT / 2) / GAME_FRAME_RT;

  // 10 ms of stable level before the debounced state changes.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = SYSTEM_FREQ / 100;

  localparam int unsigned KEY_JUMP  = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_PAUSE = 3;

  typedef enum logic {
    INT_IDLE = 1'b0,
    INT_HELD = 1'b1
  } int_state_e;

endpackage

// File: rtl/key_debouncer.sv
// Per-key conditioning: two-flop synchroniser, stability counter and
// debounced level register, plus a one-cycle rise pulse.
//   clk, reset : system clock, asynchronous active-low reset
//   key_raw    : raw asynchronous key level, 1 = pressed
//   level      : debounced key level
//   rise       : high for the first cycle in which level is 1
module key_debouncer
  import input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level_prev <= 1'b0;
      level      <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= key_raw;
      sync2      <= sync1;
      level_prev <= level;
      // Any cycle where the synchronised input agrees with the debounced
      // level restarts the stability window, so short glitches never
      // accumulate enough count to toggle the level.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/multi_key_input_controller.sv
// Multi-key input controller: debounces NUM_KEYS buttons, latches enabled
// presses per game frame and raises a level interrupt to the CPU, held
// until acknowledged.
//   clk, reset    : 100 MHz system clock, asynchronous active-low reset
//   keys_in       : raw key levels, 1 = pressed
//   key_enable    : per-key press-event mask
//   int_ack       : CPU acknowledge pulse
//   frame_tick    : one-cycle pulse at the last cycle of each frame
//   key_state     : debounced key levels
//   key_events    : press snapshot for the frame being serviced
//   key_interrupt : level interrupt, held until int_ack
//   overrun       : sticky, presses arrived while interrupt was held
//
// Handshake: key_interrupt is a level; the CPU reads key_events while it
// is 1 and pulses int_ack for one cycle. int_ack with key_interrupt=0 is
// ignored. An ack coinciding with frame_tick is applied first, so the
// same tick may immediately load a fresh snapshot.
module multi_key_input_controller
  import input_ctrl_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FRAME_CYCLES    = DEFAULT_FRAME_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic [NUM_KEYS-1:0] key_enable,
  input  logic                int_ack,
  output logic                frame_tick,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_events,
  output logic                key_interrupt,
  output logic                overrun
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

  // ---------------------------------------------------------------
  // Per-key synchroniser + debouncer
  // ---------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_rise;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_raw(keys_in[i]),
      .level  (key_state[i]),
      .rise   (key_rise[i])
    );
  end

  // ---------------------------------------------------------------
  // Free-running frame counter
  // ---------------------------------------------------------------
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign frame_tick = (frame_cnt == FRAME_LAST);

  // ---------------------------------------------------------------
  // Pending/snapshot registers and interrupt FSM
  // ---------------------------------------------------------------
  int_state_e          int_state;
  int_state_e          int_state_d;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pending_d;
  logic [NUM_KEYS-1:0] key_events_d;
  logic                overrun_d;
  logic [NUM_KEYS-1:0] new_press;
  logic                ack_ok;

  assign new_press = key_rise & key_enable;
  assign ack_ok    = int_ack && (int_state == INT_HELD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_state  <= INT_IDLE;
      pending    <= '0;
      key_events <= '0;
      overrun    <= 1'b0;
    end else begin
      int_state  <= int_state_d;
      pending    <= pending_d;
      key_events <= key_events_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    int_state_d  = int_state;
    pending_d    = pending | new_press;
    key_events_d = key_events;
    overrun_d    = overrun;

    if (ack_ok) begin
      int_state_d  = INT_IDLE;
      key_events_d = '0;
      overrun_d    = 1'b0;
    end

    // The tick looks at the post-ack interrupt state. A press detected in
    // this same cycle is kept back for the next frame rather than dropped.
    if (frame_tick && (pending != '0)) begin
      if (int_state_d == INT_IDLE) begin
        key_events_d = pending;
        int_state_d  = INT_HELD;
        pending_d    = new_press;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign key_interrupt = (int_state == INT_HELD);

endmodule
